m_ucode_store: RTL and testbench

//  Parametrised, writable microcode control store. Successor to the fixed 3-EBR ROM.
//  - Width: NBANKS x 16-bit banks. Depth: 2**AW words.
//  - Registered read path, advanced by progress_ucode.
//  - Loader FSM fills the store from a 16-bit valid/ready stream after reset,
//    so microcode can be patched without re-synthesis.
//  - Sits between the microcode sequencer (drives minx) and the control decode (consumes d).

---
 rtl/m_ucode_store.sv | 88 ++++++++
 tb/tb_m_ucode_store.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/m_ucode_store.sv
// m_ucode_store: writable NBANKS x 16-bit microcode store with stream loader; optional parity via UCODE_PARITY_EN
module m_ucode_store #(
  parameter int NBANKS = 3,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         minx,
  input  logic                  progress_ucode,
  output logic [16*NBANKS-1:0]  d,
  input  logic                  ld_start,
  input  logic [15:0]           ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  perr
);
`ifdef UCODE_PARITY_EN
  localparam int MW = 17;
`else
  localparam int MW = 16;
`endif
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
  state_t state, state_nx;
  logic [BW-1:0] bk;
  logic [AW-1:0] wa;
  logic acc, last_bk, last, rd_en;
  logic [NBANKS-1:0][MW-1:0] rd;
  logic [16*NBANKS-1:0] dw;
  assign acc = state == LOAD && ld_valid;
  assign last_bk = bk == BW'(NBANKS - 1);
  assign last = acc && last_bk && &wa;
  assign rd_en = progress_ucode && state == IDLE;
  assign ld_ready = state == LOAD;
  assign ld_busy = state != IDLE;
  assign ld_done = state == FIN;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // loader sequencing; ld_start is only honoured from IDLE
  always_comb
    state_nx = state == IDLE ? (ld_start ? LOAD : IDLE) :
               state == LOAD ? (last ? FIN : LOAD) : IDLE;
  // word counter split into bank and address to avoid a divide by NBANKS
  always_ff @(posedge clk)
    if (rst || state == IDLE) begin
      bk <= '0;
      wa <= '0;
    end else if (acc) begin
      bk <= last_bk ? '0 : bk + 1'b1;
      wa <= wa + AW'(last_bk);
    end
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [MW-1:0] mem [0:2**AW-1];
    // unreset array so each bank maps onto one block RAM
    always_ff @(posedge clk)
      if (!rst && acc && bk == BW'(b))
`ifdef UCODE_PARITY_EN
        mem[wa] <= {^ld_data, ld_data};
`else
        mem[wa] <= ld_data;
`endif
    assign rd[b] = mem[minx];
    assign dw[16*b +: 16] = rd[b][15:0];
  end
  // registered read, frozen while the loader owns the store
  always_ff @(posedge clk)
    if (rst)
      d <= '0;
    else if (rd_en)
      d <= dw;
`ifdef UCODE_PARITY_EN
  logic [NBANKS-1:0] pe;
  for (genvar p = 0; p < NBANKS; p++) begin : g_par
    assign pe[p] = ^rd[p];
  end
  // parity flag tracks d with the same latency
  always_ff @(posedge clk)
    if (rst)
      perr <= 1'b0;
    else if (rd_en)
      perr <= |pe;
`else
  assign perr = 1'b0;
`endif
endmodule

// File: tb/tb_m_ucode_store.sv
// tb_m_ucode_store: randomized scoreboard bench for m_ucode_store (NBANKS=3, AW=8)
module tb_m_ucode_store;
  localparam int NB = 3;
  localparam int AW = 8;
  localparam int NW = NB * (2**AW);
  typedef struct packed {
    logic [16*NB-1:0] d;
    logic             p;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [AW-1:0] minx = '0;
  logic progress_ucode = 0, ld_start = 0, ld_valid = 0;
  logic [15:0] ld_data = '0;
  logic [16*NB-1:0] d;
  logic ld_ready, ld_busy, ld_done, perr;
  int checks = 0, errors = 0;
  exp_t sbq[$];
  exp_t e;
  logic en;
  logic [15:0] mdl [NW];
  bit bad [2**AW];

  m_ucode_store #(.NBANKS(NB), .AW(AW)) dut (
    .clk(clk), .rst(rst), .minx(minx), .progress_ucode(progress_ucode), .d(d),
    .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16*NB-1:0] mword(int a);
    logic [16*NB-1:0] w;
    for (int b = 0; b < NB; b++) w[16*b +: 16] = mdl[a*NB + b];
    return w;
  endfunction

  task automatic push_exp(int a);
    exp_t x;
    x.d = mword(a);
    x.p = bad[a];
    sbq.push_back(x);
  endtask

  task automatic issue_rd(int a);
    @(negedge clk);
    minx = AW'(a);
    progress_ucode = 1;
    push_exp(a);
    @(negedge clk);
    progress_ucode = 0;
  endtask

  task automatic start_load();
    @(negedge clk);
    ld_start = 1;
    @(negedge clk);
    ld_start = 0;
  endtask

  task automatic stream(int n, bit tog, bit rnd, bit poke_start);
    int acc = 0, cyc = 0, early = 0;
    while (acc < n && cyc < 8*NW) begin
      @(negedge clk);
      if (ld_done) early++;
      ld_valid = tog ? (cyc % 2 == 1) : 1'b1;
      ld_data = rnd ? 16'($urandom) : 16'(acc);
      ld_start = poke_start && acc == 50;
      if (ld_valid && ld_ready) begin
        mdl[acc] = ld_data;
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    ld_valid = 0;
    ld_start = 0;
    chk("accepted_words", 64'(acc), 64'(n));
    chk("no_early_done", 64'(early), 0);
  endtask

  task automatic finish_chk();
    chk("fin_done", 64'(ld_done), 1);
    chk("fin_busy", 64'(ld_busy), 1);
    chk("fin_ready", 64'(ld_ready), 0);
    @(negedge clk);
    chk("post_done", 64'(ld_done), 0);
    chk("post_busy", 64'(ld_busy), 0);
  endtask

  // monitor: any edge where a read is legal must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    #2;
    en = progress_ucode && !ld_busy && !rst;
    @(posedge clk);
    #1;
    if (en) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %0h expected none", d);
      end else begin
        e = sbq.pop_front();
        chk("rd_d", 64'(d), 64'(e.d));
        chk("rd_perr", 64'(perr), 64'(e.p));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_d", 64'(d), 0);
    chk("rst_ready", 64'(ld_ready), 0);
    chk("rst_busy", 64'(ld_busy), 0);
    chk("rst_done", 64'(ld_done), 0);
    chk("rst_perr", 64'(perr), 0);
    rst = 0;
    start_load();
    stream(NW, 0, 0, 0);
    finish_chk();
    issue_rd(5);
    chk("d_addr5", 64'(d), 64'({16'd17, 16'd16, 16'd15}));
    minx = 9;
    repeat (2) @(negedge clk);
    chk("d_hold", 64'(d), 64'({16'd17, 16'd16, 16'd15}));
    issue_rd(9);
    chk("d_addr9", 64'(d), 64'({16'd29, 16'd28, 16'd27}));
    repeat (15) issue_rd(int'($urandom_range(0, 2**AW - 1)));
    @(negedge clk);
    minx = 7;
    progress_ucode = 1;
    ld_start = 1;
    push_exp(7);
    @(negedge clk);
    progress_ucode = 0;
    ld_start = 0;
    chk("start_with_read_busy", 64'(ld_busy), 1);
    stream(NW, 1, 1, 1);
    finish_chk();
    repeat (20) issue_rd(int'($urandom_range(0, 2**AW - 1)));
    start_load();
    stream(100, 0, 1, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(ld_busy), 0);
    chk("abort_done", 64'(ld_done), 0);
    chk("abort_ready", 64'(ld_ready), 0);
    @(negedge clk);
    chk("abort_done_later", 64'(ld_done), 0);
    issue_rd(10);
    issue_rd(33);
    issue_rd(40);
    start_load();
    stream(NW, 0, 1, 0);
    finish_chk();
    issue_rd(0);
    chk("reload_word0", 64'(d[15:0]), 64'(mdl[0]));
    repeat (20) issue_rd(int'($urandom_range(0, 2**AW - 1)));
`ifdef UCODE_PARITY_EN
    @(negedge clk);
    dut.g_bank[1].mem[3][5] = ~dut.g_bank[1].mem[3][5];
    mdl[3*NB + 1][5] = ~mdl[3*NB + 1][5];
    bad[3] = 1;
    issue_rd(3);
    chk("perr_set", 64'(perr), 1);
    issue_rd(4);
    chk("perr_clear", 64'(perr), 0);
`endif
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
